// File: rtl/zombie_target_gen.sv
// rtl/zombie_target_gen.sv - whack-a-target game: LFSR target pick, timed rounds, hit/miss scoring
// Optional build macro: ZOMBIE_NO_REPEAT_EN (consecutive targets always differ)

module zombie_target_gen #(
   parameter int                NUM_TGT = 3,
   parameter int                LFSR_W  = 16,
   parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED    = {{(LFSR_W-1){1'b0}}, 1'b1},
   parameter int                TIMEOUT = 31250000,
   parameter int                GAP     = 6250000,
   parameter int                SCORE_W = 8,
   localparam int               IDX_W   = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic [NUM_TGT-1:0] i_btn,
   output logic [NUM_TGT-1:0] o_tgt_led,
   output logic [IDX_W-1:0]   o_tgt_idx,
   output logic               o_hit,
   output logic               o_miss,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_busy
);

   localparam logic [LFSR_W-1:0] SEED_EFF   = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;
   localparam logic [31:0]       TIMEOUT_LD = 32'(TIMEOUT - 1);
   localparam logic [31:0]       GAP_LD     = 32'(GAP - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_TGT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_SHOW,
      S_GAP
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [NUM_TGT-1:0]   r_btn_s1;
   logic [NUM_TGT-1:0]   r_btn_s2;
   logic [NUM_TGT-1:0]   r_btn_prev;
   logic [NUM_TGT-1:0]   r_btn_edge;
   logic [1:0]           r_warm;
   logic                 r_start_d;
   logic [LFSR_W-1:0]    r_lfsr;
   logic [31:0]          r_cnt;
   logic [IDX_W-1:0]     r_tgt_idx;
   logic [SCORE_W-1:0]   r_score;

   logic                 w_start_rise;
   logic [IDX_W+7:0]     w_prod;
   logic [IDX_W-1:0]     w_pick;
   logic [IDX_W-1:0]     w_arm_idx;
   logic [NUM_TGT-1:0]   w_onehot;
   logic                 w_good;
   logic                 w_bad;
   logic                 w_hit;
   logic                 w_miss;

   assign w_start_rise = i_start & ~r_start_d;

   // Scale the low LFSR byte into 0..NUM_TGT-1 without a divider.
   assign w_prod = (IDX_W + 8)'(r_lfsr[7:0]) * (IDX_W + 8)'(NUM_TGT);
   assign w_pick = IDX_W'(w_prod >> 8);

`ifdef ZOMBIE_NO_REPEAT_EN
   assign w_arm_idx = (w_pick != r_tgt_idx) ? w_pick :
                      (w_pick == LAST_IDX)  ? '0     : w_pick + IDX_W'(1);
`else
   assign w_arm_idx = w_pick;
`endif

   assign w_onehot = {{(NUM_TGT-1){1'b0}}, 1'b1} << r_tgt_idx;
   assign w_good   = |(r_btn_edge & w_onehot);
   assign w_bad    = |(r_btn_edge & ~w_onehot);

   // Button synchronizers and rising-edge pulses; edges are masked until the
   // pipeline has refilled after reset so a held button cannot look like a press.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_btn_s1   <= '0;
         r_btn_s2   <= '0;
         r_btn_prev <= '0;
         r_btn_edge <= '0;
         r_warm     <= 2'd0;
      end else begin
         r_btn_s1   <= i_btn;
         r_btn_s2   <= r_btn_s1;
         r_btn_prev <= r_btn_s2;
         r_btn_edge <= r_btn_s2 & ~r_btn_prev & {NUM_TGT{r_warm == 2'd3}};
         if (r_warm != 2'd3) begin
            r_warm <= r_warm + 2'd1;
         end
      end
   end

   // Free-running Galois LFSR, stepped every cycle regardless of game state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lfsr <= SEED_EFF;
      end else begin
         r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
      end
   end

   // Game state register and start-level history.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_start_d <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_start_d <= i_start;
      end
   end

   // Next-state and hit/miss decode; stop outranks everything, a wrong press
   // outranks a correct one, and any press outranks the timeout.
   always_comb begin
      w_next = r_state;
      w_hit  = 1'b0;
      w_miss = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!i_stop && w_start_rise) begin
               w_next = S_ARM;
            end
         end
         S_ARM: begin
            w_next = i_stop ? S_IDLE : S_SHOW;
         end
         S_SHOW: begin
            if (i_stop) begin
               w_next = S_IDLE;
            end else if (w_bad) begin
               w_miss = 1'b1;
               w_next = S_GAP;
            end else if (w_good) begin
               w_hit  = 1'b1;
               w_next = S_GAP;
            end else if (r_cnt == '0) begin
               w_miss = 1'b1;
               w_next = S_GAP;
            end
         end
         S_GAP: begin
            if (i_stop) begin
               w_next = S_IDLE;
            end else if (r_cnt == '0) begin
               w_next = S_ARM;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Shared round timer: lit time in SHOW, dark time in GAP.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_ARM:   r_cnt <= TIMEOUT_LD;
            S_SHOW:  r_cnt <= (w_next == S_GAP) ? GAP_LD : r_cnt - 32'd1;
            S_GAP:   r_cnt <= r_cnt - 32'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Target latch in ARM and saturating score, cleared when a game begins.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tgt_idx <= '0;
         r_score   <= '0;
      end else begin
         if (r_state == S_ARM && w_next == S_SHOW) begin
            r_tgt_idx <= w_arm_idx;
         end
         if (r_state == S_IDLE && w_next == S_ARM) begin
            r_score <= '0;
         end else if (w_hit && r_score != '1) begin
            r_score <= r_score + SCORE_W'(1);
         end
      end
   end

   assign o_tgt_led = (r_state == S_SHOW) ? w_onehot : '0;
   assign o_tgt_idx = r_tgt_idx;
   assign o_hit     = w_hit;
   assign o_miss    = w_miss;
   assign o_score   = r_score;
   assign o_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_zombie_target_gen.sv
// tb/tb_zombie_target_gen.sv - round-level checks of zombie_target_gen against a game model

module tb_zombie_target_gen;

   localparam int NT   = 4;
   localparam int SW   = 2;
   localparam int TO   = 20;
   localparam int GP   = 5;
   localparam int SMAX = (1 << SW) - 1;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_start = 1'b0;
   logic          i_stop = 1'b0;
   logic [NT-1:0] i_btn = '0;
   logic [NT-1:0] o_tgt_led;
   logic [1:0]    o_tgt_idx;
   logic          o_hit;
   logic          o_miss;
   logic [SW-1:0] o_score;
   logic          o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_lfsr;
   int          m_prev;
   int          m_score;

   typedef struct {
      int kind;
      int press_at;
      int exp_score;
   } vec_t;

   vec_t tbl[9];

   zombie_target_gen #(
      .NUM_TGT (NT),
      .LFSR_W  (16),
      .TAPS    (16'hB400),
      .SEED    (16'd1),
      .TIMEOUT (TO),
      .GAP     (GP),
      .SCORE_W (SW)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (i_start),
      .i_stop    (i_stop),
      .i_btn     (i_btn),
      .o_tgt_led (o_tgt_led),
      .o_tgt_idx (o_tgt_idx),
      .o_hit     (o_hit),
      .o_miss    (o_miss),
      .o_score   (o_score),
      .o_busy    (o_busy)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      logic [15:0] y;
      y = x >> 1;
      if (x[0]) y = y ^ 16'hB400;
      return y;
   endfunction

   function automatic int pick(input logic [15:0] l);
      return (int'(l[7:0]) * NT) / 256;
   endfunction

   // Reference copy of the free-running LFSR.
   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) m_lfsr <= 16'd1;
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Called at the ARM sample point; plays one round and returns at the next ARM sample.
   // kind: 0 none, 1 correct, 2 wrong, 3 correct+wrong together.
   task automatic do_round(input int kind, input int press_at, output int got_idx);
      int            exp_idx;
      int            wrong;
      int            c_end;
      bit            exp_hit;
      logic [NT-1:0] mask;
      chk("arm_busy", int'(o_busy), 1);
      chk("arm_led", int'(o_tgt_led), 0);
      chk("arm_pulse", int'(o_hit | o_miss), 0);
      exp_idx = pick(m_lfsr);
`ifdef ZOMBIE_NO_REPEAT_EN
      if (exp_idx == m_prev) exp_idx = (exp_idx + 1) % NT;
`endif
      m_prev = exp_idx;
      wrong  = (exp_idx + 1 + int'($urandom_range(0, NT - 2))) % NT;
      mask   = '0;
      if (kind == 1 || kind == 3) mask[exp_idx] = 1'b1;
      if (kind == 2 || kind == 3) mask[wrong]   = 1'b1;
      if (kind != 0 && press_at + 3 <= TO) begin
         c_end   = press_at + 3;
         exp_hit = (kind == 1);
      end else begin
         c_end   = TO;
         exp_hit = 1'b0;
      end
      got_idx = 0;
      for (int c = 1; c <= c_end; c++) begin
         step();
         if (c == 1) got_idx = int'(o_tgt_idx);
         chk("show_led", int'(o_tgt_led), 1 << exp_idx);
         chk("show_idx", int'(o_tgt_idx), exp_idx);
         chk("show_idx_range", int'(o_tgt_idx < NT), 1);
         chk("show_hit", int'(o_hit), int'(c == c_end && exp_hit));
         chk("show_miss", int'(o_miss), int'(c == c_end && !exp_hit));
         if (kind != 0 && c == press_at)     i_btn = mask;
         if (kind != 0 && c == press_at + 1) i_btn = '0;
         if (c == 3) i_start = 1'b0;
         if (c == 4) i_start = 1'b1;
      end
      if (exp_hit && m_score < SMAX) m_score++;
      for (int g = 1; g <= GP; g++) begin
         step();
         chk("gap_led", int'(o_tgt_led), 0);
         chk("gap_pulse", int'(o_hit | o_miss), 0);
         chk("gap_busy", int'(o_busy), 1);
         chk("gap_score", int'(o_score), m_score);
      end
      step();
   endtask

   initial begin
      int idx;
      int prev_idx;
      int seen[NT];
      int kind;
      int exp_idx;

      tbl[0] = '{kind: 1, press_at: 2,  exp_score: 1};
      tbl[1] = '{kind: 1, press_at: 5,  exp_score: 2};
      tbl[2] = '{kind: 2, press_at: 3,  exp_score: 2};
      tbl[3] = '{kind: 3, press_at: 4,  exp_score: 2};
      tbl[4] = '{kind: 1, press_at: 1,  exp_score: 3};
      tbl[5] = '{kind: 1, press_at: 17, exp_score: 3};
      tbl[6] = '{kind: 1, press_at: 18, exp_score: 3};
      tbl[7] = '{kind: 0, press_at: 1,  exp_score: 3};
      tbl[8] = '{kind: 1, press_at: 10, exp_score: 3};

      m_prev  = 0;
      m_score = 0;

      // Reset state, with every button held through reset release.
      i_btn = '1;
      repeat (3) step();
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_led", int'(o_tgt_led), 0);
      chk("rst_idx", int'(o_tgt_idx), 0);
      chk("rst_hit", int'(o_hit), 0);
      chk("rst_miss", int'(o_miss), 0);
      chk("rst_score", int'(o_score), 0);

      i_rst   = 1'b0;
      i_start = 1'b1;
      step();
      chk("start_busy", int'(o_busy), 1);
      chk("start_score", int'(o_score), 0);

      // Held buttons must not register: pure timeout round.
      do_round(0, 1, idx);
      i_btn = '0;

      for (int i = 0; i < 9; i++) begin
         do_round(tbl[i].kind, tbl[i].press_at, idx);
         chk($sformatf("tbl%0d_score", i), int'(o_score), tbl[i].exp_score);
      end

      // Stop in the middle of SHOW, then restart clears score.
      exp_idx = pick(m_lfsr);
`ifdef ZOMBIE_NO_REPEAT_EN
      if (exp_idx == m_prev) exp_idx = (exp_idx + 1) % NT;
`endif
      m_prev = exp_idx;
      for (int c = 1; c <= 5; c++) begin
         step();
         chk("pre_stop_led", int'(o_tgt_led), 1 << exp_idx);
      end
      i_stop = 1'b1;
      step();
      chk("stop_busy", int'(o_busy), 0);
      chk("stop_led", int'(o_tgt_led), 0);
      chk("stop_pulse", int'(o_hit | o_miss), 0);
      chk("stop_score", int'(o_score), 3);
      i_stop  = 1'b0;
      i_start = 1'b0;
      step();
      chk("idle_busy", int'(o_busy), 0);
      i_start = 1'b1;
      step();
      m_score = 0;
      chk("restart_score", int'(o_score), 0);

      // Long randomized game: target coverage and scoring.
      for (int i = 0; i < NT; i++) seen[i] = 0;
      prev_idx = -1;
      for (int r = 0; r < 1000; r++) begin
         kind = int'($urandom_range(0, 9));
         if (kind >= 1 && kind <= 5) kind = 1;
         else if (kind >= 6 && kind <= 7) kind = 2;
         else if (kind >= 8) kind = 3;
         do_round(kind, int'($urandom_range(1, 19)), idx);
         if (idx >= 0 && idx < NT) seen[idx]++;
`ifdef ZOMBIE_NO_REPEAT_EN
         if (prev_idx >= 0) chk("no_repeat", int'(idx != prev_idx), 1);
`endif
         prev_idx = idx;
      end
      for (int i = 0; i < NT; i++) begin
         chk($sformatf("seen_idx%0d", i), int'(seen[i] > 0), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/zombie_target_gen.md
ZOMBIE_TARGET_GEN -- requirements
Module: zombie_target_gen

Interface
REQ-001 Parameter NUM_TGT, 3, number of targets/buttons (2..16).
REQ-002 Parameter LFSR_W, 16, LFSR width (8..32).
REQ-003 Parameter TAPS, 16'hB400, Galois feedback mask (maximal length for LFSR_W).
REQ-004 Parameter SEED, 1, LFSR reset value; value 0 SHALL be replaced by 1.
REQ-005 Parameter TIMEOUT, 31250000, cycles a target stays lit before a miss.
REQ-006 Parameter GAP, 6250000, cycles all targets are dark between rounds.
REQ-007 Parameter SCORE_W, 8, score counter width.
REQ-008 clk  in  1  system clock.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 start  in  1  level; begin play on rising edge.
REQ-011 stop  in  1  level; abort play while high.
REQ-012 btn  in  NUM_TGT  raw asynchronous push buttons, active-high.
REQ-013 tgt_led  out  NUM_TGT  one-hot lit target, all-zero when dark.
REQ-014 tgt_idx  out  clog2(NUM_TGT)  index of current target.
REQ-015 hit  out  1  one-cycle pulse on correct press.
REQ-016 miss  out  1  one-cycle pulse on wrong press or timeout.
REQ-017 score  out  SCORE_W  hits this game, saturating.
REQ-018 busy  out  1  high in any state except IDLE.

Function
REQ-019 Each btn bit SHALL pass a 2-flop synchronizer, then rising-edge detect; edge pulse = 1 cycle, 3 cycles after the first sampled high.
REQ-020 LFSR SHALL step every clk cycle (Galois, shift right, XOR TAPS when LSB=1), independent of FSM state.
REQ-021 Target pick: idx = (lfsr[7:0] * NUM_TGT) >> 8, always < NUM_TGT.
REQ-022 FSM states IDLE, ARM, SHOW, GAP.
REQ-023 IDLE -> ARM on start rising edge; score cleared to 0 on that edge.
REQ-024 ARM (1 cycle): latch idx into tgt_idx, load timeout counter to TIMEOUT-1; -> SHOW.
REQ-025 SHOW: tgt_led = one-hot(tgt_idx); counter decrements each cycle.
REQ-026 SHOW, edge on btn[tgt_idx] only: hit=1, score+1 (saturate at all-ones), -> GAP.
REQ-027 SHOW, edge on any other btn (with or without correct): miss=1, score unchanged, -> GAP.
REQ-028 SHOW, counter=0 with no edge: miss=1, -> GAP; an edge in the same cycle takes priority per REQ-026/027.
REQ-029 GAP: tgt_led=0, GAP-1 cycle countdown, edges ignored; -> ARM at 0.
REQ-030 stop high in any state: -> IDLE next cycle, tgt_led=0, no hit/miss, score held.
REQ-031 start edge while busy SHALL be ignored; hit and miss never both high.

Reset
REQ-032 rst SHALL force IDLE, lfsr=SEED (or 1), synchronizers 0, tgt_led=0, tgt_idx=0, hit=0, miss=0, score=0, busy=0.
REQ-033 rst asserted mid-round SHALL abandon the round; no hit/miss pulse on release.
REQ-034 Buttons held during reset release SHALL NOT generate an edge.

Configuration
REQ-035 Macro ZOMBIE_NO_REPEAT_EN defined: if picked idx equals previous tgt_idx, ARM SHALL use (idx+1) mod NUM_TGT; consecutive targets always differ.
REQ-036 Macro undefined: picked idx used unchanged; repeats allowed.

Verification
REQ-037 rst then start, TIMEOUT=20, GAP=5, no buttons -> miss at SHOW cycle 20, tgt_led dark 5 cycles, new target lit.
REQ-038 Press btn[tgt_idx] in SHOW -> hit 1 cycle, score 0->1, tgt_led=0 next cycle.
REQ-039 Press correct and wrong button same cycle -> miss only, score unchanged.
REQ-040 SCORE_W=2, 5 hits -> score 1,2,3,3,3.
REQ-041 stop mid-SHOW -> busy=0, tgt_led=0 next cycle, score held; start again -> score 0.
REQ-042 NUM_TGT=4, 1000 rounds -> every idx seen, none >= 4; with ZOMBIE_NO_REPEAT_EN no two consecutive equal.
